// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC op codes,
// reset PC and fetch FSM state encoding.
package ifu_fetch_pkg;

  typedef enum logic [2:0] {
    NPC_PC4 = 3'd0,
    NPC_BEQ = 3'd1,
    NPC_JAL = 3'd2,
    NPC_JR  = 3'd3
  } npc_op_e;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

endpackage

// File: rtl/ifu_fetch_npc_calc.sv
// Purely combinational next-PC computation for beq / jal / jr / sequential flow.
module npc_calc
  import ifu_fetch_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [2:0]  next_pc_op,
  input  logic        cmp_eq,
  input  logic [15:0] imm,
  input  logic [25:0] j_address,
  input  logic [31:0] jr_data,
  output logic [31:0] next_pc
);

  npc_op_e     op;
  logic [31:0] branch_off;

  assign op         = npc_op_e'(next_pc_op);
  assign branch_off = {{14{imm[15]}}, imm, 2'b00};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    next_pc = pc_plus4;
    case (op)
      NPC_BEQ: if (cmp_eq) next_pc = pc_plus4 + branch_off;
      NPC_JAL: next_pc = {pc_plus4[31:28], j_address, 2'b00};
      NPC_JR:  next_pc = {jr_data[31:2], 2'b00};
      default: next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and
// presents the word to the decoder until commit.
module ifu_fetch
  import ifu_fetch_pkg::state_e, ifu_fetch_pkg::ST_REQ, ifu_fetch_pkg::ST_EXEC;
#(
  parameter logic [31:0] PC_RESET = ifu_fetch_pkg::PC_RESET,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  next_pc_op,
  input  logic        cmp_eq,
  input  logic [15:0] imm,
  input  logic [25:0] j_address,
  input  logic [31:0] jr_data,
  input  logic        commit,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  state_e      state, state_next;
  logic        load_instr, take_pc, in_range;
  logic [31:0] instr_next, next_pc;
  logic [32:0] pc_ext, base_ext, limit_ext;

  assign pc_plus4 = pc + 32'd4;
  assign im_addr  = {pc[31:2], 2'b00};

  // 33-bit compare so a window ending at 2^32 does not wrap to zero.
  assign pc_ext    = {1'b0, pc};
  assign base_ext  = {1'b0, IM_BASE};
  assign limit_ext = base_ext + (33'(IM_DEPTH) << 2);
  assign in_range  = (pc_ext >= base_ext) && (pc_ext < limit_ext);

  assign im_req = (state == ST_REQ) && in_range && !reset;

  npc_calc u_npc_calc (
    .pc_plus4   (pc_plus4),
    .next_pc_op (next_pc_op),
    .cmp_eq     (cmp_eq),
    .imm        (imm),
    .j_address  (j_address),
    .jr_data    (jr_data),
    .next_pc    (next_pc)
  );

  always_comb begin
    state_next = state;
    load_instr = 1'b0;
    take_pc    = 1'b0;
    instr_next = instr;
    case (state)
      ST_REQ: begin
        if (!in_range) begin
          // Unbacked address: hand the decoder a nop instead of stalling forever.
          load_instr = 1'b1;
          instr_next = 32'h0;
          state_next = ST_EXEC;
        end else if (im_ack) begin
          load_instr = 1'b1;
          instr_next = im_rdata;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (commit) begin
          take_pc    = 1'b1;
          state_next = ST_REQ;
        end
      end
      default: state_next = ST_REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_REQ;
      pc          <= PC_RESET;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (load_instr) begin
        instr       <= instr_next;
        instr_valid <= 1'b1;
      end
      if (take_pc) begin
        pc          <= next_pc;
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Randomized self-checking bench for ifu_fetch against a transaction-level
// model of the fetch/commit sequence and next-PC rules.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  next_pc_op;
  logic        cmp_eq;
  logic [15:0] imm;
  logic [25:0] j_address;
  logic [31:0] jr_data;
  logic        commit;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  ifu_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc_op  (next_pc_op),
    .cmp_eq      (cmp_eq),
    .imm         (imm),
    .j_address   (j_address),
    .jr_data     (jr_data),
    .commit      (commit),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ack      (im_ack),
    .im_rdata    (im_rdata),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic bit in_im(input logic [31:0] a);
    longint x;
    x = a;
    return (x >= 64'h3000) && (x < 64'h3000 + 4 * 4096);
  endfunction

  function automatic logic [31:0] ref_npc(input logic [31:0] p, input int op, input bit eq,
                                          input logic [15:0] im, input logic [25:0] j,
                                          input logic [31:0] r);
    logic [31:0] link;
    int          off;
    link = p + 32'd4;
    off  = int'($signed(im)) * 4;
    case (op)
      1:       return eq ? link + 32'(off) : link;
      2:       return (link & 32'hF000_0000) | (32'(j) * 32'd4);
      3:       return r & 32'hFFFF_FFFC;
      default: return link;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One REQ phase: ack after `delay` wait cycles; stray commits must be ignored.
  task automatic fetch(input int delay);
    if (in_im(m_pc)) begin
      for (int i = 0; i < delay; i++) begin
        im_ack = 1'b0;
        commit = 1'($urandom_range(0, 1));
        check("req_wait", im_req, 1);
        check("addr_wait", im_addr, m_pc);
        check("valid_wait", instr_valid, 0);
        step();
      end
      im_ack   = 1'b1;
      im_rdata = word_of(m_pc);
      commit   = 1'($urandom_range(0, 1));
      check("req_ack", im_req, 1);
      check("addr_ack", im_addr, m_pc);
      step();
      im_ack  = 1'b0;
      commit  = 1'b0;
      m_instr = word_of(m_pc);
    end else begin
      im_ack   = 1'($urandom_range(0, 1));
      im_rdata = $urandom;
      check("req_oor", im_req, 0);
      step();
      im_ack  = 1'b0;
      m_instr = 32'h0;
    end
    check("instr_fetched", instr, m_instr);
    check("valid_fetched", instr_valid, 1);
    check("pc_fetched", pc, m_pc);
  endtask

  // One EXEC phase: hold for `hold` cycles (stray acks ignored), then commit.
  task automatic execute(input int hold, input logic [2:0] op, input bit eq,
                         input logic [15:0] im, input logic [25:0] j, input logic [31:0] r);
    for (int i = 0; i < hold; i++) begin
      commit   = 1'b0;
      im_ack   = 1'($urandom_range(0, 1));
      im_rdata = $urandom;
      step();
      check("instr_hold", instr, m_instr);
      check("pc_hold", pc, m_pc);
    end
    im_ack     = 1'b0;
    next_pc_op = op;
    cmp_eq     = eq;
    imm        = im;
    j_address  = j;
    jr_data    = r;
    commit     = 1'b1;
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    step();
    commit = 1'b0;
    m_pc   = ref_npc(m_pc, int'(op), eq, im, j, r);
    check("pc_next", pc, m_pc);
    check("valid_clear", instr_valid, 0);
  endtask

  task automatic reset_mid_req();
    im_ack   = 1'b1;
    im_rdata = $urandom;
    #3;
    reset = 1'b1;
    #1;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_req", im_req, 0);
    im_ack = 1'b0;
    step();
    check("rst_hold_valid", instr_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    m_pc  = 32'h0000_3000;
    #1;
    check("post_rst_req", im_req, 1);
    check("post_rst_addr", im_addr, 32'h0000_3000);
  endtask

  initial begin
    reset      = 1'b1;
    next_pc_op = 3'd0;
    cmp_eq     = 1'b0;
    imm        = 16'h0;
    j_address  = 26'h0;
    jr_data    = 32'h0;
    commit     = 1'b0;
    im_ack     = 1'b0;
    im_rdata   = 32'h0;
    m_pc       = 32'h0000_3000;
    m_instr    = 32'h0;
    #12;
    check("reset_req", im_req, 0);
    check("reset_pc", pc, 32'h0000_3000);
    check("reset_instr", instr, 0);
    check("reset_valid", instr_valid, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("first_req", im_req, 1);
    check("first_addr", im_addr, 32'h0000_3000);

    // Directed sequence following the fetch/branch scenarios.
    fetch(0); execute(0, 3'd0, 0, 16'h0, 26'h0, 32'h0);             // -> 0x3004
    fetch(3); execute(1, 3'd0, 0, 16'h0, 26'h0, 32'h0);             // -> 0x3008
    fetch(1); execute(0, 3'd1, 1, 16'hFFFF, 26'h0, 32'h0);          // -> 0x3008
    fetch(0); execute(2, 3'd1, 0, 16'hFFFF, 26'h0, 32'h0);          // -> 0x300C
    fetch(0); execute(0, 3'd5, 1, 16'h0010, 26'h0, 32'h0);          // -> 0x3010
    fetch(2); execute(0, 3'd2, 0, 16'h0, 26'h0000C20, 32'h0);       // -> 0x3080
    fetch(0); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'h0000_3000);     // -> 0x3000
    fetch(0); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'h0000_3007);     // -> 0x3004
    fetch(0); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'hFFFF_FFFF);     // -> 0xFFFFFFFC
    fetch(0); execute(0, 3'd0, 0, 16'h0, 26'h0, 32'h0);             // wraps to 0
    fetch(0); execute(1, 3'd3, 0, 16'h0, 26'h0, 32'h0000_6FFC);     // last word
    fetch(1); execute(0, 3'd0, 0, 16'h0, 26'h0, 32'h0);             // -> 0x7000, first unbacked
    fetch(0); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'h0000_3000);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] r;
      logic [25:0] j;
      r = ($urandom_range(0, 3) == 0) ? $urandom : 32'h3000 + $urandom_range(0, 16383);
      j = 26'(32'h0C00 + $urandom_range(0, 4095));
      fetch($urandom_range(0, 3));
      execute($urandom_range(0, 2), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              16'($urandom), j, r);
    end

    // Reset mid-REQ on a backed address with an ack pending.
    fetch(0); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'h0000_3100);
    reset_mid_req();
    fetch(1); execute(0, 3'd3, 0, 16'h0, 26'h0, 32'h0001_0000);

    // Out-of-range fetch yields a nop, then reset during the following REQ.
    fetch(0); execute(0, 3'd0, 0, 16'h0, 26'h0, 32'h0);             // -> 0x10004
    check("oor_req", im_req, 0);
    reset_mid_req();
    fetch(0); execute(0, 3'd0, 0, 16'h0, 26'h0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction-fetch stage of the MIPS core, directly upstream of the control unit.
- Holds the PC and requests instructions from an instruction memory over a req/ack handshake.
- Presents the fetched word as `instr` to the decoder until execution commits.
- On commit, computes the next PC from the decoder's `next_pc_op` and the branch, jump and register operands.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, first byte address backed by instruction memory.
- IM_DEPTH, 4096, instruction memory size in 32-bit words.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- next_pc_op  in  3  0=pc+4, 1=beq, 2=jal, 3=jr, 4..7 treated as pc+4.
- cmp_eq  in  1  beq condition: operands equal.
- imm  in  16  branch offset, in words, signed.
- j_address  in  26  jal target field.
- jr_data  in  32  GRF read-1 value for jr.
- commit  in  1  current instruction finishes execution this cycle.
- im_req  out  1  memory read request.
- im_addr  out  32  word-aligned read address.
- im_ack  in  1  read data valid this cycle.
- im_rdata  in  32  read data.
- instr  out  32  instruction word to the control unit.
- instr_valid  out  1  `instr` holds a fetched, uncommitted instruction.
- pc  out  32  address of `instr`.
- pc_plus4  out  32  pc+4, used as the jal link value.

Behaviour:
- Reset is asynchronous and active-high; `clk` is the only clock.
- Reset values:
  - pc = PC_RESET
  - instr = 0
  - instr_valid = 0
  - state = REQ
  - im_req = 0 during reset, 1 in the first cycle after reset deasserts.
- FSM states: REQ, EXEC.
- REQ:
  - If pc is in range, im_req = 1 and im_addr = pc; both stay stable until im_ack.
  - On im_ack sampled high at a clock edge: instr <= im_rdata, instr_valid <= 1, go to EXEC.
  - An ack in the same cycle as the request is legal, giving 1-cycle fetch against combinational memory.
- In-range test: IM_BASE <= pc < IM_BASE + 4*IM_DEPTH, evaluated in 33-bit arithmetic.
- Out-of-range pc:
  - im_req stays 0.
  - Next edge: instr <= 0 (nop), instr_valid <= 1, go to EXEC.
- EXEC:
  - instr and pc are held.
  - On commit: pc <= next_pc, instr_valid <= 0, go to REQ.
- Ignored inputs:
  - im_ack outside REQ, or while im_req = 0.
  - commit outside EXEC.
- next_pc, all sums modulo 2^32 (0xFFFF_FFFC + 4 = 0):
  - op 1 with cmp_eq = 1: pc_plus4 + (sign_ext(imm) << 2).
  - op 1 with cmp_eq = 0: pc_plus4.
  - op 2: {pc_plus4[31:28], j_address, 2'b00}.
  - op 3: {jr_data[31:2], 2'b00}; low two bits are discarded.
  - other codes: pc_plus4.
- pc_plus4 is combinational from pc.
- Minimum instruction period is 2 cycles (REQ plus EXEC with immediate ack and commit).
- Reset asserted at any time, including mid-REQ with ack pending or coincident with commit: state returns to reset values immediately; any pending ack is dropped.

Decomposition:
- Shared package holds:
  - next_pc_op encodings (NPC_PC4=0, NPC_BEQ=1, NPC_JAL=2, NPC_JR=3).
  - PC_RESET.
  - FSM state encoding.
- One natural sub-module: `npc_calc`, purely combinational next-PC computation, reusable by later pipelined versions.

Test Plan:
- Reset released, memory acks in the same cycle -> im_addr=0x0000_3000; instr = rdata and instr_valid=1 on the next edge.
- Ack delayed 3 cycles -> im_req and im_addr=0x3000 stable throughout; instr_valid rises only after the ack edge.
- pc=0x3008, op=1, cmp_eq=1, imm=0xFFFF, commit -> pc=0x3008; same with cmp_eq=0 -> pc=0x300C.
- pc=0x3010, op=2, j_address=0x0000C20, commit -> pc=0x0000_3080.
- pc=0x3000, op=3, jr_data=0x0000_3007 -> pc=0x3004.
- pc driven out of range via jr, jr_data=0x0001_0000:
  - im_req stays 0 and instr=0 with valid next cycle.
  - Then reset asserted mid-REQ with an ack pending -> pc=0x3000, instr_valid=0 asynchronously.
